// File: rtl/bottle_fill_ctrl.sv
// Bottle fill controller: counts pill strobes against a latched BCD target,
// closes each bottle on reaching it and keeps a BCD tally of completed bottles.
module bottle_fill_ctrl #(
    parameter int DIGITS       = 2,
    parameter int TALLY_DIGITS = 3
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      start,
    input  logic                      halt,
    input  logic                      clr_tally,
    input  logic                      pill,
    input  logic                      conti,
    input  logic                      step_mode,
    input  logic                      allFull,
    input  logic [4*DIGITS-1:0]       max_bcd,
    output logic [4*DIGITS-1:0]       pill_bcd,
    output logic [4*TALLY_DIGITS-1:0] tally_bcd,
    output logic                      bottle_done,
    output logic                      wait_conti,
    output logic                      busy,
    output logic                      cfg_err,
    output logic                      drop_err
);

    localparam int PW = 4 * DIGITS;
    localparam int TW = 4 * TALLY_DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   target_q, target_d;
    logic [PW-1:0]   pill_q, pill_d;
    logic [PW-1:0]   pill_next;
    logic [TW-1:0]   tally_q, tally_d;
    logic            done_q, done_d;
    logic            wait_q, wait_d;
    logic            busy_q, busy_d;
    logic            cfg_q, cfg_d;
    logic            drop_q, drop_d;

    // Ripple BCD increment: a 9 rolls to 0 and passes the carry upward.
    function automatic logic [PW-1:0] pill_inc(input logic [PW-1:0] v);
        logic [PW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [TW-1:0] tally_inc(input logic [TW-1:0] v);
        logic [TW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < TALLY_DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic target_valid(input logic [PW-1:0] v);
        logic ok;
        ok = (v != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            target_q <= '0;
            pill_q   <= '0;
            tally_q  <= '0;
            done_q   <= 1'b0;
            wait_q   <= 1'b0;
            busy_q   <= 1'b0;
            cfg_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            pill_q   <= pill_d;
            tally_q  <= tally_d;
            done_q   <= done_d;
            wait_q   <= wait_d;
            busy_q   <= busy_d;
            cfg_q    <= cfg_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        pill_d    = pill_q;
        tally_d   = tally_q;
        done_d    = 1'b0;
        cfg_d     = cfg_q;
        drop_d    = drop_q;
        pill_next = pill_inc(pill_q);

        if (halt) begin
            state_d = IDLE;
            pill_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (target_valid(max_bcd)) begin
                            state_d  = FILL;
                            target_d = max_bcd;
                            pill_d   = '0;
                            cfg_d    = 1'b0;
                            drop_d   = 1'b0;
                        end else begin
                            cfg_d = 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (pill) begin
                        if (allFull) begin
                            drop_d = 1'b1;
                        end else if (pill_next == target_q) begin
                            pill_d  = '0;
                            tally_d = tally_inc(tally_q);
                            done_d  = 1'b1;
                            state_d = step_mode ? WAIT : FILL;
                        end else begin
                            pill_d = pill_next;
                        end
                    end
                end
                WAIT: begin
                    if (pill) begin
                        drop_d = 1'b1;
                    end
                    if (conti) begin
                        state_d = FILL;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // A clear wins over a coincident completion; bottle_done still pulses.
        if (clr_tally) begin
            tally_d = '0;
        end

        busy_d = (state_d != IDLE);
        wait_d = (state_d == WAIT);
    end

    assign pill_bcd    = pill_q;
    assign tally_bcd   = tally_q;
    assign bottle_done = done_q;
    assign wait_conti  = wait_q;
    assign busy        = busy_q;
    assign cfg_err     = cfg_q;
    assign drop_err    = drop_q;

endmodule

// File: tb/tb_bottle_fill_ctrl.sv
// Scoreboard bench for bottle_fill_ctrl: an integer-arithmetic reference model
// queues the expected outputs per cycle and a monitor compares them after each edge.
module tb_bottle_fill_ctrl;

    localparam int DIGITS       = 2;
    localparam int TALLY_DIGITS = 3;
    localparam int TALLY_MOD    = 1000;
    localparam int S_IDLE       = 0;
    localparam int S_FILL       = 1;
    localparam int S_WAIT       = 2;

    logic        CLK;
    logic        RST;
    logic        start;
    logic        halt;
    logic        clr_tally;
    logic        pill;
    logic        conti;
    logic        step_mode;
    logic        allFull;
    logic [7:0]  max_bcd;
    logic [7:0]  pill_bcd;
    logic [11:0] tally_bcd;
    logic        bottle_done;
    logic        wait_conti;
    logic        busy;
    logic        cfg_err;
    logic        drop_err;

    typedef struct {
        logic [7:0]  pill;
        logic [11:0] tally;
        logic        done;
        logic        waitc;
        logic        busy;
        logic        cfg;
        logic        drop;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int error_count = 0;
    int check_count = 0;

    int m_state  = S_IDLE;
    int m_pc     = 0;
    int m_target = 0;
    int m_tally  = 0;
    bit m_cfg    = 1'b0;
    bit m_drop   = 1'b0;

    bottle_fill_ctrl #(
        .DIGITS       (DIGITS),
        .TALLY_DIGITS (TALLY_DIGITS)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .halt        (halt),
        .clr_tally   (clr_tally),
        .pill        (pill),
        .conti       (conti),
        .step_mode   (step_mode),
        .allFull     (allFull),
        .max_bcd     (max_bcd),
        .pill_bcd    (pill_bcd),
        .tally_bcd   (tally_bcd),
        .bottle_done (bottle_done),
        .wait_conti  (wait_conti),
        .busy        (busy),
        .cfg_err     (cfg_err),
        .drop_err    (drop_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int          n;
        r = '0;
        n = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    function automatic int bcd_value(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit target_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v != 8'h00);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances and queues what the DUT must show after the edge.
    task automatic applyStimulus(input logic st, input logic hl, input logic cl, input logic pl,
                                 input logic co, input logic sm, input logic af,
                                 input logic [7:0] mx);
        exp_t        e;
        logic [31:0] tmp;
        @(negedge CLK);
        start     = st;
        halt      = hl;
        clr_tally = cl;
        pill      = pl;
        conti     = co;
        step_mode = sm;
        allFull   = af;
        max_bcd   = mx;

        e.done = 1'b0;
        if (hl) begin
            m_state = S_IDLE;
            m_pc    = 0;
        end else if (m_state == S_IDLE) begin
            if (st) begin
                if (target_ok(mx)) begin
                    m_state  = S_FILL;
                    m_target = bcd_value(mx);
                    m_pc     = 0;
                    m_cfg    = 1'b0;
                    m_drop   = 1'b0;
                end else begin
                    m_cfg = 1'b1;
                end
            end
        end else if (m_state == S_FILL) begin
            if (pl) begin
                if (af) begin
                    m_drop = 1'b1;
                end else begin
                    m_pc++;
                    if (m_pc == m_target) begin
                        m_pc    = 0;
                        m_tally = (m_tally + 1) % TALLY_MOD;
                        e.done  = 1'b1;
                        m_state = sm ? S_WAIT : S_FILL;
                    end
                end
            end
        end else begin
            if (pl) m_drop = 1'b1;
            if (co) m_state = S_FILL;
        end
        if (cl) m_tally = 0;

        tmp     = to_bcd(m_pc);
        e.pill  = tmp[7:0];
        tmp     = to_bcd(m_tally);
        e.tally = tmp[11:0];
        e.waitc = (m_state == S_WAIT);
        e.busy  = (m_state != S_IDLE);
        e.cfg   = m_cfg;
        e.drop  = m_drop;
        exp_q.push_back(e);
    endtask

    task automatic idleCycle;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic startCycle(input logic [7:0] mx);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mx);
    endtask

    task automatic haltCycle;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic clrCycle;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic pillCycle(input logic sm, input logic af);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, sm, af, 8'h00);
    endtask

    task automatic afterEdge;
        @(posedge CLK);
        #3;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_pill"},  32'(pill_bcd),    32'h0);
        checkOutput({tag, "_tally"}, 32'(tally_bcd),   32'h0);
        checkOutput({tag, "_done"},  32'(bottle_done), 32'h0);
        checkOutput({tag, "_wait"},  32'(wait_conti),  32'h0);
        checkOutput({tag, "_busy"},  32'(busy),        32'h0);
        checkOutput({tag, "_cfg"},   32'(cfg_err),     32'h0);
        checkOutput({tag, "_drop"},  32'(drop_err),    32'h0);
    endtask

    // Reset is raised between edges and checked before the next edge arrives.
    task automatic doAsyncReset;
        @(negedge CLK);
        start = 1'b0; halt = 1'b0; clr_tally = 1'b0; pill = 1'b0;
        conti = 1'b0; step_mode = 1'b0; allFull = 1'b0; max_bcd = 8'h00;
        #2 RST = 1'b1;
        #1 checkAllZero("async_rst");
        @(negedge CLK);
        RST      = 1'b0;
        m_state  = S_IDLE;
        m_pc     = 0;
        m_target = 0;
        m_tally  = 0;
        m_cfg    = 1'b0;
        m_drop   = 1'b0;
    endtask

    always @(posedge CLK) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checkOutput("sb_pill_bcd",    32'(pill_bcd),    32'(mon_e.pill));
            checkOutput("sb_tally_bcd",   32'(tally_bcd),   32'(mon_e.tally));
            checkOutput("sb_bottle_done", 32'(bottle_done), 32'(mon_e.done));
            checkOutput("sb_wait_conti",  32'(wait_conti),  32'(mon_e.waitc));
            checkOutput("sb_busy",        32'(busy),        32'(mon_e.busy));
            checkOutput("sb_cfg_err",     32'(cfg_err),     32'(mon_e.cfg));
            checkOutput("sb_drop_err",    32'(drop_err),    32'(mon_e.drop));
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rb;
        logic        r_st, r_hl, r_cl, r_pl, r_co, r_sm, r_af;
        logic [7:0]  r_mx;

        RST = 1'b1;
        start = 1'b0; halt = 1'b0; clr_tally = 1'b0; pill = 1'b0;
        conti = 1'b0; step_mode = 1'b0; allFull = 1'b0; max_bcd = 8'h00;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1 checkAllZero("reset");

        // Auto-continue with target 12 over two bottles.
        startCycle(8'h12);
        for (int i = 1; i <= 24; i++) begin
            pillCycle(1'b0, 1'b0);
            if (i == 10) begin
                afterEdge;
                checkOutput("t1_pill_at_10", 32'(pill_bcd), 32'h10);
            end
            if (i == 12 || i == 24) begin
                afterEdge;
                checkOutput("t1_done", 32'(bottle_done), 32'h1);
                checkOutput("t1_pill_zero", 32'(pill_bcd), 32'h00);
                checkOutput("t1_tally", 32'(tally_bcd), (i == 12) ? 32'h001 : 32'h002);
                checkOutput("t1_busy", 32'(busy), 32'h1);
            end
        end

        // Step mode: WAIT after the bottle, extra pills dropped, conti resumes.
        haltCycle;
        clrCycle;
        startCycle(8'h03);
        for (int i = 1; i <= 3; i++) pillCycle(1'b1, 1'b0);
        afterEdge;
        checkOutput("t2_wait", 32'(wait_conti), 32'h1);
        checkOutput("t2_done", 32'(bottle_done), 32'h1);
        pillCycle(1'b1, 1'b0);
        pillCycle(1'b1, 1'b0);
        afterEdge;
        checkOutput("t2_drop", 32'(drop_err), 32'h1);
        checkOutput("t2_pill_held", 32'(pill_bcd), 32'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        pillCycle(1'b1, 1'b0);
        afterEdge;
        checkOutput("t2_pill_after_conti", 32'(pill_bcd), 32'h01);

        // Invalid targets are rejected, a valid one clears the flag.
        haltCycle;
        startCycle(8'h00);
        afterEdge;
        checkOutput("t3_cfg_zero", 32'(cfg_err), 32'h1);
        checkOutput("t3_busy_zero", 32'(busy), 32'h0);
        startCycle(8'h1A);
        afterEdge;
        checkOutput("t3_cfg_1a", 32'(cfg_err), 32'h1);
        checkOutput("t3_busy_1a", 32'(busy), 32'h0);
        startCycle(8'h20);
        afterEdge;
        checkOutput("t3_cfg_clear", 32'(cfg_err), 32'h0);

        // Tray full blocks counting.
        for (int i = 0; i < 4; i++) pillCycle(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) pillCycle(1'b0, 1'b1);
        afterEdge;
        checkOutput("t4_pill_blocked", 32'(pill_bcd), 32'h04);
        checkOutput("t4_drop", 32'(drop_err), 32'h1);
        pillCycle(1'b0, 1'b0);
        afterEdge;
        checkOutput("t4_pill_resume", 32'(pill_bcd), 32'h05);

        // halt keeps the tally.
        haltCycle;
        clrCycle;
        startCycle(8'h01);
        for (int i = 0; i < 4; i++) pillCycle(1'b0, 1'b0);
        haltCycle;
        startCycle(8'h10);
        for (int i = 0; i < 5; i++) pillCycle(1'b0, 1'b0);
        haltCycle;
        afterEdge;
        checkOutput("t5_pill", 32'(pill_bcd), 32'h00);
        checkOutput("t5_tally", 32'(tally_bcd), 32'h004);
        checkOutput("t5_busy", 32'(busy), 32'h0);

        // Asynchronous reset mid-fill.
        startCycle(8'h10);
        for (int i = 0; i < 7; i++) pillCycle(1'b0, 1'b0);
        afterEdge;
        checkOutput("t6_pill_pre", 32'(pill_bcd), 32'h07);
        doAsyncReset;

        // Tally boundary: clear coinciding with completion, then silent wrap.
        startCycle(8'h01);
        for (int i = 0; i < 999; i++) pillCycle(1'b0, 1'b0);
        afterEdge;
        checkOutput("t7_tally_999", 32'(tally_bcd), 32'h999);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        afterEdge;
        checkOutput("t7_clr_tally", 32'(tally_bcd), 32'h000);
        checkOutput("t7_clr_done", 32'(bottle_done), 32'h1);
        for (int i = 0; i < 999; i++) pillCycle(1'b0, 1'b0);
        pillCycle(1'b0, 1'b0);
        afterEdge;
        checkOutput("t7_wrap_tally", 32'(tally_bcd), 32'h000);
        checkOutput("t7_wrap_done", 32'(bottle_done), 32'h1);
        haltCycle;

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r_st = ($urandom_range(0, 14) == 0);
            r_hl = ($urandom_range(0, 59) == 0);
            r_cl = ($urandom_range(0, 49) == 0);
            r_pl = 1'($urandom_range(0, 1));
            r_co = ($urandom_range(0, 4) == 0);
            r_sm = 1'($urandom_range(0, 1));
            r_af = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 9) < 7) begin
                rb   = to_bcd(int'($urandom_range(1, 15)));
                r_mx = rb[7:0];
            end else begin
                r_mx = 8'($urandom_range(0, 255));
            end
            applyStimulus(r_st, r_hl, r_cl, r_pl, r_co, r_sm, r_af, r_mx);
        end
        idleCycle;
        afterEdge;

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
